// File: rtl/pc_request_unit.sv
// Program counter and instruction/data memory request sequencer.
// The PC advances only after an instruction fully completes: on ihit for
// non-memory instructions, or on dhit for loads and stores.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | instruction read requested, waiting for ihit
// DATA   | data read/write requested, waiting for dhit; npc_q holds the
//        | next PC captured at ihit
// HALTED | HALT retired; all requests off, PC frozen until nRST
module pc_request_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        halt_in,
  input  logic [1:0]  PC_src,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_addr,
  input  logic [31:0] reg_target,
  output logic [31:0] imemaddr,
  output logic [31:0] pc_plus4,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic        halt
);

  typedef enum logic [1:0] {FETCH, DATA, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] npc_q, npc_nxt;
  logic        rd_q, rd_nxt;
  logic        wr_q, wr_nxt;
  logic        pc_en_q, pc_en_nxt;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;
  assign imemaddr = pc;
  assign pc_en    = pc_en_q;

  // Next-PC selection; jr targets pass through without alignment fix-up.
  always_comb begin
    next_pc = pc_plus4;
    case (PC_src)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + (branch_off << 2);
      2'b10: next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
      2'b11: next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // State, PC and captured request registers; reset aborts any data request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      npc_q   <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pc_en_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      npc_q   <= npc_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      pc_en_q <= pc_en_nxt;
    end
  end

  // Next-state logic; halt_in wins over a memory op in the same instruction.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    npc_nxt   = npc_q;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    pc_en_nxt = 1'b0;
    case (state)
      FETCH: begin
        if (ihit) begin
          if (halt_in) begin
            state_nxt = HALTED;
          end else if (MemRead || MemWrite) begin
            npc_nxt   = next_pc;
            rd_nxt    = MemRead;
            wr_nxt    = MemWrite;
            state_nxt = DATA;
          end else begin
            pc_nxt    = next_pc;
            pc_en_nxt = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_nxt    = npc_q;
          pc_en_nxt = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Memory request outputs decoded from state; a store wins over a load.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    halt    = 1'b0;
    case (state)
      FETCH:  imemREN = 1'b1;
      DATA: begin
        dmemWEN = wr_q;
        dmemREN = rd_q & ~wr_q;
      end
      HALTED: halt = 1'b1;
      default: imemREN = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pc_request_unit.sv
// Directed bench for pc_request_unit: expected outputs are queued as each
// step is driven and compared against the DUT after the following edge.
module tb_pc_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, MemRead, MemWrite, halt_in;
  logic [1:0]  PC_src;
  logic [31:0] branch_off, reg_target;
  logic [25:0] jump_addr;
  logic [31:0] imemaddr, pc_plus4;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        imem, dren, dwen, pen, hlt;
  } exp_t;

  exp_t sb[$];

  pc_request_unit #(.PC_RESET(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .MemRead(MemRead), .MemWrite(MemWrite), .halt_in(halt_in),
    .PC_src(PC_src), .branch_off(branch_off), .jump_addr(jump_addr),
    .reg_target(reg_target), .imemaddr(imemaddr), .pc_plus4(pc_plus4),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt)
  );

  // 10 ns system clock
  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic imem, input logic dren, input logic dwen,
                            input logic pen, input logic hlt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.imem = imem; e.dren = dren;
    e.dwen = dwen; e.pen = pen; e.hlt = hlt;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "pc",       imemaddr,        e.pc);
    cmp(e.tag, "pc_plus4", pc_plus4,        e.pc + 32'd4);
    cmp(e.tag, "imemREN",  {31'b0, imemREN}, {31'b0, e.imem});
    cmp(e.tag, "dmemREN",  {31'b0, dmemREN}, {31'b0, e.dren});
    cmp(e.tag, "dmemWEN",  {31'b0, dmemWEN}, {31'b0, e.dwen});
    cmp(e.tag, "pc_en",    {31'b0, pc_en},   {31'b0, e.pen});
    cmp(e.tag, "halt",     {31'b0, halt},    {31'b0, e.hlt});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    compare_out();
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; MemRead = 0; MemWrite = 0; halt_in = 0;
    PC_src = 2'b00;
  endtask

  task automatic do_reset(input string tag);
    #2;
    nRST = 0;
    #1;
    expect_out(tag, 32'h0, 1, 0, 0, 0, 0);
    compare_out();
    #2;
    nRST = 1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 0;
    idle_inputs();
    branch_off = 32'h0; jump_addr = 26'h0; reg_target = 32'h0;
    #3;
    expect_out("reset", 32'h0, 1, 0, 0, 0, 0);
    compare_out();
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK);
    #1;

    // sequential fetch: 0 -> 4 -> 8 -> C
    ihit = 1;
    expect_out("seq1", 32'h4, 1, 0, 0, 1, 0); tick();
    expect_out("seq2", 32'h8, 1, 0, 0, 1, 0); tick();
    expect_out("seq3", 32'hC, 1, 0, 0, 1, 0); tick();
    ihit = 0;
    expect_out("no_ihit", 32'hC, 1, 0, 0, 0, 0); tick();
    ihit = 1;
    expect_out("seq4", 32'h10, 1, 0, 0, 1, 0); tick();

    // branch back, jump, register
    PC_src = 2'b01; branch_off = 32'hFFFF_FFFE;
    expect_out("branch", 32'h0C, 1, 0, 0, 1, 0); tick();
    PC_src = 2'b10; jump_addr = 26'h000_0040;
    expect_out("jump", 32'h100, 1, 0, 0, 1, 0); tick();
    PC_src = 2'b11; reg_target = 32'h8000_0000;
    expect_out("jr", 32'h8000_0000, 1, 0, 0, 1, 0); tick();
    reg_target = 32'h0000_0013;
    expect_out("jr_misaligned", 32'h13, 1, 0, 0, 1, 0); tick();
    reg_target = 32'h0000_0020;
    expect_out("jr_20", 32'h20, 1, 0, 0, 1, 0); tick();

    // load at 0x20 with a 3-cycle dhit wait
    PC_src = 2'b00; MemRead = 1;
    expect_out("load_req", 32'h20, 0, 1, 0, 0, 0); tick();
    MemRead = 0; PC_src = 2'b10; jump_addr = 26'h3FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      ihit = (i == 1);
      expect_out("load_wait", 32'h20, 0, 1, 0, 0, 0); tick();
    end
    ihit = 0; dhit = 1;
    expect_out("load_done", 32'h24, 1, 0, 0, 1, 0); tick();
    dhit = 0; PC_src = 2'b00;
    expect_out("after_load", 32'h24, 1, 0, 0, 0, 0); tick();

    // store with both MemRead and MemWrite, aborted by reset
    ihit = 1; MemRead = 1; MemWrite = 1;
    expect_out("store_req", 32'h24, 0, 0, 1, 0, 0); tick();
    idle_inputs();
    expect_out("store_wait", 32'h24, 0, 0, 1, 0, 0); tick();
    do_reset("reset_mid_data");

    // jump to 0x40 then HALT with MemWrite
    ihit = 1; PC_src = 2'b11; reg_target = 32'h40;
    expect_out("jr_40", 32'h40, 1, 0, 0, 1, 0); tick();
    PC_src = 2'b00; halt_in = 1; MemWrite = 1;
    expect_out("halt_enter", 32'h40, 0, 0, 0, 0, 1); tick();
    halt_in = 0; MemWrite = 0;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom_range(0, 1));
      dhit = 1'($urandom_range(0, 1));
      MemRead = 1'($urandom_range(0, 1));
      expect_out("halted", 32'h40, 0, 0, 0, 0, 1); tick();
    end
    idle_inputs();
    do_reset("reset_halt");

    // wrap-around and ignored dhit in FETCH
    ihit = 1; PC_src = 2'b11; reg_target = 32'hFFFF_FFFC;
    expect_out("jr_top", 32'hFFFF_FFFC, 1, 0, 0, 1, 0); tick();
    ihit = 0; dhit = 1; PC_src = 2'b00;
    expect_out("dhit_fetch", 32'hFFFF_FFFC, 1, 0, 0, 0, 0); tick();
    ihit = 1;
    expect_out("wrap", 32'h0, 1, 0, 0, 1, 0); tick();

    // minimum-latency store: ihit then dhit on the next cycle
    dhit = 0; MemWrite = 1;
    expect_out("store2_req", 32'h0, 0, 0, 1, 0, 0); tick();
    ihit = 0; MemWrite = 0; dhit = 1;
    expect_out("store2_done", 32'h4, 1, 0, 0, 1, 0); tick();
    idle_inputs();
    expect_out("idle_end", 32'h4, 1, 0, 0, 0, 0); tick();

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
